// File: rtl/spi_fake_miso_tx.sv
// SPI mode-0 MISO injector: serialises a held fake word (or passes the real slave through)
// locked to the sniffed SCLK/SS_n. Optional MISO_OE_EN adds a miso_oe pin-drive enable.
module spi_fake_miso_tx #(
    parameter int DATA_SIZE   = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 bus_sclk,
    input  logic                 bus_ss_n,
    input  logic                 real_miso,
    input  logic [DATA_SIZE-1:0] fake_data,
    input  logic                 fake_select,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 miso_out,
    output logic                 word_done,
    output logic                 underrun,
`ifdef MISO_OE_EN
    output logic                 miso_oe,
`endif
    output logic                 aborted
);

    localparam int CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Index 0 is the first synchroniser flop; the extra top flop holds the previous
    // synchronised value so edges are taken between the two oldest stages.
    logic [SYNC_STAGES:0] sclk_sync_q;
    logic [SYNC_STAGES:0] ss_sync_q;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic                 active_fake_q, active_fake_d;
    logic                 pend_xfer_q, pend_xfer_d;
    logic [DATA_SIZE-1:0] hold_data_q, hold_data_d;
    logic                 hold_sel_q, hold_sel_d;
    logic                 hold_full_q, hold_full_d;
    logic                 word_done_q, word_done_d;
    logic                 underrun_q, underrun_d;
    logic                 aborted_q, aborted_d;

    logic                 sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic                 xfer;
    logic [DATA_SIZE-1:0] shift_next;
    logic                 shift_out_bit;
    logic                 drive_fake;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], bus_sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-1:0], bus_ss_n};
        end
    end

    assign sclk_rise =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_sync_q[SYNC_STAGES];
    assign ss_fall   = ~ss_sync_q[SYNC_STAGES-1]   &  ss_sync_q[SYNC_STAGES];
    assign ss_rise   =  ss_sync_q[SYNC_STAGES-1]   & ~ss_sync_q[SYNC_STAGES];

    // Shift toward the output end, so the next bit to send always sits there.
    assign shift_next = MSB_FIRST ? {shift_q[DATA_SIZE-2:0], 1'b0}
                                  : {1'b0, shift_q[DATA_SIZE-1:1]};
    assign shift_out_bit = MSB_FIRST ? shift_q[DATA_SIZE-1] : shift_q[0];

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            active_fake_q <= 1'b0;
            pend_xfer_q   <= 1'b0;
            hold_data_q   <= '0;
            hold_sel_q    <= 1'b0;
            hold_full_q   <= 1'b0;
            word_done_q   <= 1'b0;
            underrun_q    <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            active_fake_q <= active_fake_d;
            pend_xfer_q   <= pend_xfer_d;
            hold_data_q   <= hold_data_d;
            hold_sel_q    <= hold_sel_d;
            hold_full_q   <= hold_full_d;
            word_done_q   <= word_done_d;
            underrun_q    <= underrun_d;
            aborted_q     <= aborted_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        active_fake_d = active_fake_q;
        pend_xfer_d   = pend_xfer_q;
        hold_data_d   = hold_data_q;
        hold_sel_d    = hold_sel_q;
        hold_full_d   = hold_full_q;
        word_done_d   = 1'b0;
        underrun_d    = 1'b0;
        aborted_d     = 1'b0;
        xfer          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    xfer        = 1'b1;
                    state_d     = SHIFT;
                    bit_cnt_d   = '0;
                    pend_xfer_d = 1'b0;
                end
            end
            SHIFT: begin
                // SS_n release wins over any coincident SCLK edge, including the
                // final SCLK fall, so no transfer is started after the frame ends.
                if (ss_rise) begin
                    state_d     = IDLE;
                    pend_xfer_d = 1'b0;
                    aborted_d   = (bit_cnt_q != '0);
                end else begin
                    if (sclk_rise) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            word_done_d = 1'b1;
                            bit_cnt_d   = '0;
                            pend_xfer_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        if (pend_xfer_q) begin
                            xfer        = 1'b1;
                            pend_xfer_d = 1'b0;
                        end else begin
                            shift_d = shift_next;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (data_valid && !hold_full_q) begin
            hold_data_d = fake_data;
            hold_sel_d  = fake_select;
            hold_full_d = 1'b1;
        end

        // A transfer sees the holding register as it was at the start of the cycle;
        // a same-cycle load into an empty holding register stays for the next word.
        if (xfer) begin
            if (hold_full_q) begin
                shift_d       = hold_data_q;
                active_fake_d = hold_sel_q;
                hold_full_d   = 1'b0;
            end else begin
                active_fake_d = 1'b0;
                underrun_d    = 1'b1;
            end
        end
    end

    assign drive_fake = (state_q == SHIFT) && active_fake_q;
    assign miso_out   = drive_fake ? shift_out_bit : real_miso;
    assign data_ready = ~hold_full_q;
    assign word_done  = word_done_q;
    assign underrun   = underrun_q;
    assign aborted    = aborted_q;

`ifdef MISO_OE_EN
    assign miso_oe = drive_fake;
`endif

endmodule

// File: tb/tb_spi_fake_miso_tx.sv
// Directed bench for spi_fake_miso_tx: expected MISO bits are queued as words are staged
// and popped at each SCLK sample edge; event pulses are counted per frame.
module tb_spi_fake_miso_tx;

    logic       sys_clk     = 1'b0;
    logic       rst         = 1'b1;
    logic       bus_sclk    = 1'b0;
    logic       bus_ss_n    = 1'b1;
    logic       real_miso   = 1'b0;
    logic [7:0] fake_data   = '0;
    logic       fake_select = 1'b0;
    logic       data_valid  = 1'b0;
    logic       data_ready, miso_out, word_done, underrun, aborted;
`ifdef MISO_OE_EN
    logic       miso_oe;
`endif

    typedef struct packed {
        logic miso;
        logic oe;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   wd_n  = 0;
    int   ur_n  = 0;
    int   ab_n  = 0;
    int   wd0, ur0, ab0;

    always #5 sys_clk = ~sys_clk;

    spi_fake_miso_tx #(.DATA_SIZE(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .bus_sclk   (bus_sclk),
        .bus_ss_n   (bus_ss_n),
        .real_miso  (real_miso),
        .fake_data  (fake_data),
        .fake_select(fake_select),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .miso_out   (miso_out),
        .word_done  (word_done),
        .underrun   (underrun),
`ifdef MISO_OE_EN
        .miso_oe    (miso_oe),
`endif
        .aborted    (aborted)
    );

    always @(negedge sys_clk) begin
        if (word_done) wd_n++;
        if (underrun)  ur_n++;
        if (aborted)   ab_n++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue n bits of one word: fake bits MSB first, or the real pattern from rpat[base+b].
    task automatic push_bits(input logic [7:0] d, input logic fake, input int base,
                             input logic [31:0] rpat, input int n);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            e.miso = fake ? d[7-b] : rpat[base+b];
            e.oe   = fake;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_bit(input int idx);
        exp_t e;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("miso_bit%0d", idx), 32'(miso_out), 32'(e.miso));
`ifdef MISO_OE_EN
            check($sformatf("oe_bit%0d", idx), 32'(miso_oe), 32'(e.oe));
`endif
        end
    endtask

    task automatic load(input logic [7:0] d, input logic sel);
        fake_data   = d;
        fake_select = sel;
        data_valid  = 1'b1;
        tick(1);
        data_valid  = 1'b0;
    endtask

    // One SCLK period: real slave launches on the fall, master samples just before the rise.
    task automatic sclk_bit(input logic r, input int idx);
        real_miso = r;
        tick(8);
        check_bit(idx);
        bus_sclk = 1'b1;
        tick(8);
        bus_sclk = 1'b0;
    endtask

    task automatic frame(input int nbits, input logic [31:0] rpat, input int load_at,
                         input logic [7:0] ld);
        bus_ss_n  = 1'b0;
        real_miso = rpat[0];
        tick(8);
        check("ready_after_ssfall", 32'(data_ready), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (i == load_at) begin
                check("ready_mid", 32'(data_ready), 32'd1);
                load(ld, 1'b1);
            end
            sclk_bit(rpat[i], i);
            if (i == nbits - 1) bus_ss_n = 1'b1;
        end
        tick(8);
    endtask

    task automatic snap();
        wd0 = wd_n;
        ur0 = ur_n;
        ab0 = ab_n;
    endtask

    task automatic check_events(input string tag, input int wd, input int ur, input int ab);
        check({tag, "_word_done"}, 32'(wd_n - wd0), 32'(wd));
        check({tag, "_underrun"},  32'(ur_n - ur0), 32'(ur));
        check({tag, "_aborted"},   32'(ab_n - ab0), 32'(ab));
    endtask

    initial begin
        logic [31:0] rp;

        // Reset state
        real_miso = 1'b1;
        tick(3);
        check("rst_ready",     32'(data_ready), 32'd1);
        check("rst_word_done", 32'(word_done),  32'd0);
        check("rst_underrun",  32'(underrun),   32'd0);
        check("rst_aborted",   32'(aborted),    32'd0);
        check("rst_miso",      32'(miso_out),   32'd1);
`ifdef MISO_OE_EN
        check("rst_oe",        32'(miso_oe),    32'd0);
`endif
        rst       = 1'b0;
        real_miso = 1'b0;
        tick(4);

        // Fake word A3
        load(8'hA3, 1'b1);
        check("t1_ready_full", 32'(data_ready), 32'd0);
        push_bits(8'hA3, 1'b1, 0, 32'h0, 8);
        snap();
        frame(8, 32'h0, -1, 8'h00);
        check_events("t1", 1, 0, 0);

        // Pass-through word, real MISO toggling
        rp = 32'hAAAA_AAAA;
        load(8'h40, 1'b0);
        push_bits(8'h40, 1'b0, 0, rp, 8);
        snap();
        frame(8, rp, -1, 8'h00);
        check_events("t2", 1, 0, 0);

        // Back-to-back fake words, second loaded during word 1
        load(8'hA3, 1'b1);
        push_bits(8'hA3, 1'b1, 0, 32'h0, 8);
        push_bits(8'hFF, 1'b1, 8, 32'h0, 8);
        snap();
        frame(16, 32'h0, 2, 8'hFF);
        check_events("t3", 2, 0, 0);

        // Second word underruns and passes real MISO
        rp = 32'h0000_C500;
        load(8'hA3, 1'b1);
        push_bits(8'hA3, 1'b1, 0, rp, 8);
        push_bits(8'h00, 1'b0, 8, rp, 8);
        snap();
        frame(16, rp, -1, 8'h00);
        check_events("t4", 2, 1, 0);

        // SS_n released after 3 clocks
        load(8'h5A, 1'b1);
        push_bits(8'h5A, 1'b1, 0, 32'h0, 3);
        snap();
        frame(3, 32'h0, -1, 8'h00);
        check_events("t5", 0, 0, 1);
        real_miso = 1'b1;
        tick(1);
        check("t5_idle_miso1", 32'(miso_out), 32'd1);
        real_miso = 1'b0;
        tick(1);
        check("t5_idle_miso0", 32'(miso_out), 32'd0);

        // Reset in the middle of a fake word
        load(8'hA3, 1'b1);
        push_bits(8'hA3, 1'b1, 0, 32'h0, 4);
        bus_ss_n = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) sclk_bit(1'b0, i);
        real_miso = 1'b1;
        rst       = 1'b1;
        tick(1);
        check("t6_rst_ready",     32'(data_ready), 32'd1);
        check("t6_rst_word_done", 32'(word_done),  32'd0);
        check("t6_rst_underrun",  32'(underrun),   32'd0);
        check("t6_rst_aborted",   32'(aborted),    32'd0);
        check("t6_rst_miso",      32'(miso_out),   32'd1);
`ifdef MISO_OE_EN
        check("t6_rst_oe",        32'(miso_oe),    32'd0);
`endif
        bus_ss_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(8);

        // Next frame with nothing loaded
        rp = 32'h0000_0096;
        push_bits(8'h00, 1'b0, 0, rp, 8);
        snap();
        frame(8, rp, -1, 8'h00);
        check_events("t6", 1, 1, 0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_fake_miso_tx.md
Name: spi_fake_miso_tx

Overview:
- Bit-level transmitter that returns MitmLogic results to the bus. It serialises fake_miso_data onto the MISO line, locked to the sniffed SCLK and SS_n, in SPI mode 0.
- Each word either carries the injected fake word or passes the real slave's MISO through unchanged.
- Sits between MitmLogic (fake_miso_data/fake_miso_select/done_sig) and the MISO output pin, mirroring the sniffing receiver on the input side.

Parameters:
- DATA_SIZE, 8, bits per SPI word.
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.
- SYNC_STAGES, 2, flip-flop stages on bus_sclk and bus_ss_n before edge detection (minimum 2).

Ports:
- sys_clk  input  1  system clock; all logic in this domain.
- rst  input  1  reset, asynchronous, active-high.
- bus_sclk  input  1  sniffed SPI clock (asynchronous to sys_clk).
- bus_ss_n  input  1  sniffed slave select, active-low (asynchronous).
- real_miso  input  1  MISO from the real slave.
- fake_data  input  DATA_SIZE  word to inject.
- fake_select  input  1  1 = inject fake_data for this word, 0 = pass real MISO.
- data_valid  input  1  load strobe for fake_data/fake_select.
- data_ready  output  1  holding register empty; a load is accepted this cycle.
- miso_out  output  1  driven MISO.
- word_done  output  1  one-cycle pulse per completed word.
- underrun  output  1  one-cycle pulse when a word starts with the holding register empty.
- aborted  output  1  one-cycle pulse when SS_n rises mid-word.

Behaviour:
- Reset: data_ready=1, word_done=0, underrun=0, aborted=0; holding and shift registers cleared; state=IDLE. Synchroniser flops reset to sclk=0 and ss_n=1.
- Synchronisation: bus_sclk and bus_ss_n pass through SYNC_STAGES flops. Edges are detected on the last two stages. ss_fall, ss_rise, sclk_rise (sample edge) and sclk_fall (launch edge) are each one-cycle strobes.
- Buffering: one holding register (data + select + full flag).
  - Load when data_valid && data_ready. data_ready = !hold_full.
  - data_valid while full is ignored, with no overwrite.
  - Holding is emptied when it is transferred to the shift register.
- Transfer points: ss_fall, and the end of every word while SS_n is still low.
  - Hold full: the shift register takes the held data, and active_fake takes the held select.
  - Hold empty: active_fake=0 and underrun pulses.
- States:
  - IDLE: waits for ss_fall, then does a transfer and moves to SHIFT with bit_cnt=0.
  - SHIFT:
    - On sclk_rise: bit_cnt++.
    - If bit_cnt reaches DATA_SIZE-1 on that sclk_rise: pulse word_done, set bit_cnt=0, and do a transfer on the next sclk_fall.
    - On sclk_fall not at a word boundary: shift the register by one toward the output end.
    - On ss_rise: go to IDLE. If bit_cnt!=0, pulse aborted; no word_done for a partial word.
- Output mux (combinational):
  - miso_out = (state==SHIFT && active_fake) ? shift_out_bit : real_miso.
  - shift_out_bit is bit DATA_SIZE-1 if MSB_FIRST, else bit 0.
  - In IDLE, miso_out follows real_miso.
- Latency:
  - After ss_fall, the first fake bit is valid SYNC_STAGES+1 sys_clk cycles after the SS_n pin falls.
  - Each later bit changes SYNC_STAGES+1 cycles after the SCLK pin falls.
  - SCLK must be at most sys_clk/8 so that bits settle before the sample edge.
- Simultaneous events:
  - ss_rise and sclk_rise in the same cycle: ss_rise has priority; the count is not incremented.
  - Load in the same cycle as a transfer: the transfer takes the old held word if full. If the holding register was empty, the new load goes to holding and an underrun is still flagged.
  - Reset mid-word: immediate return to IDLE; miso_out reverts to real_miso.

Optional Feature:
- Macro MISO_OE_EN.
- Defined: adds output port miso_oe (1 bit, reset 0). miso_oe = (state==SHIFT && active_fake); when it is low, the top level tri-states or releases the pin to the real slave.
- Undefined: no miso_oe port; the mux always drives miso_out.

Test Plan:
- Load A3/select=1, run an 8-clock SS frame -> miso_out bits 1,0,1,0,0,0,1,1, one word_done, data_ready back to 1 after ss_fall.
- Load 40/select=0, real_miso toggles 0,1,0,1... -> miso_out equals real_miso every bit; word_done once.
- Load A3, then load FF during word 1; run a 16-clock frame -> words A3 then FF, 2 word_done, no underrun.
- Load A3 only; run a 16-clock frame -> word 1 is A3; at the word-2 start underrun pulses and word 2 passes real_miso.
- Load 5A; SS_n rises after 3 clocks -> aborted pulse, no word_done, state IDLE, miso_out=real_miso.
- Assert rst at bit 4 of a fake word -> all outputs at reset values; the next frame with no load gives underrun and pass-through. With MISO_OE_EN, miso_oe is high only during fake words.
